// File: rtl/ysyx_25020037_ifu_pkg.sv
// Shared configuration for the instruction fetch unit: bus width, reset PC
// and the FSM state encoding.
package ysyx_25020037_ifu_pkg;

    localparam int          FU_TO_DU_BUS_WD = 64;
    localparam logic [31:0] RESET_PC_DEF    = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ifu_state_e;

    // Redirect targets are forced onto a word boundary; no exception is raised.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_25020037_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time and hands
// {pc, inst} to decode; accepts one-cycle redirects from execute.
module ysyx_25020037_ifu
    import ysyx_25020037_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ifu_req_valid,
    input  logic                       ifu_req_ready,
    output logic [31:0]                ifu_req_addr,
    input  logic                       ifu_rsp_valid,
    input  logic [31:0]                ifu_rsp_data,
    output logic                       ifu_valid,
    input  logic                       idu_ready,
    output logic [FU_TO_DU_BUS_WD-1:0] fu_to_du_bus,
    input  logic                       exu_dnpc_valid,
    input  logic [31:0]                exu_dnpc
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; a producer never drops valid or changes its payload before
    // that edge. One response returns per accepted request.

    ifu_state_e                 state_q, state_d;
    logic [31:0]                pc_q, pc_d;
    logic                       req_valid_q, req_valid_d;
    logic [31:0]                req_addr_q, req_addr_d;
    logic                       ifu_valid_q, ifu_valid_d;
    logic [FU_TO_DU_BUS_WD-1:0] bus_q, bus_d;
    logic                       discard_q, discard_d;
    logic                       pend_q, pend_d;
    logic [31:0]                dnpc_aligned;

    assign dnpc_aligned = align_word(exu_dnpc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            req_addr_q  <= RESET_PC;
            ifu_valid_q <= 1'b0;
            bus_q       <= '0;
            discard_q   <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            ifu_valid_q <= ifu_valid_d;
            bus_q       <= bus_d;
            discard_q   <= discard_d;
            pend_q      <= pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        ifu_valid_d = ifu_valid_q;
        bus_d       = bus_q;
        discard_d   = discard_q;
        pend_d      = pend_q;

        case (state_q)
            ST_REQ: begin
                if (!req_valid_q) begin
                    // Entry cycle: nothing presented yet, so a redirect can
                    // simply retarget the request about to be launched.
                    if (exu_dnpc_valid) begin
                        pc_d       = dnpc_aligned;
                        req_addr_d = dnpc_aligned;
                    end else begin
                        req_addr_d = pc_q;
                    end
                    req_valid_d = 1'b1;
                end else begin
                    if (exu_dnpc_valid) begin
                        pc_d   = dnpc_aligned;
                        pend_d = 1'b1;
                    end
                    if (ifu_req_ready) begin
                        req_valid_d = 1'b0;
                        state_d     = ST_WAIT;
                        discard_d   = exu_dnpc_valid | pend_q;
                        pend_d      = 1'b0;
                    end
                end
            end

            ST_WAIT: begin
                if (exu_dnpc_valid) begin
                    pc_d = dnpc_aligned;
                    if (ifu_rsp_valid) begin
                        discard_d = 1'b0;
                        state_d   = ST_REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (ifu_rsp_valid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = ST_REQ;
                    end else begin
                        bus_d       = {pc_q, ifu_rsp_data};
                        ifu_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                // A redirect beats a same-cycle consume: no pc + 4 then.
                if (exu_dnpc_valid) begin
                    pc_d        = dnpc_aligned;
                    ifu_valid_d = 1'b0;
                    state_d     = ST_REQ;
                end else if (idu_ready) begin
                    pc_d        = pc_q + 32'd4;
                    ifu_valid_d = 1'b0;
                    state_d     = ST_REQ;
                end
            end

            default: begin
                state_d     = ST_REQ;
                req_valid_d = 1'b0;
                ifu_valid_d = 1'b0;
                discard_d   = 1'b0;
                pend_d      = 1'b0;
            end
        endcase
    end

    assign ifu_req_valid = req_valid_q;
    assign ifu_req_addr  = req_addr_q;
    assign ifu_valid     = ifu_valid_q;
    assign fu_to_du_bus  = bus_q;

endmodule

// File: tb/tb_ysyx_25020037_ifu.sv
// Directed bench for the fetch unit: a latency-programmable memory model, a
// scoreboard of expected requests/instructions and a monitor that checks them.
module tb_ysyx_25020037_ifu;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic        ifu_valid;
    logic        idu_ready;
    logic [63:0] fu_to_du_bus;
    logic        exu_dnpc_valid;
    logic [31:0] exu_dnpc;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    logic [31:0] exp_req_q[$];
    logic [63:0] exp_bus_q[$];
    int          acc_cyc[$];

    ysyx_25020037_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_rsp_valid  (ifu_rsp_valid),
        .ifu_rsp_data   (ifu_rsp_data),
        .ifu_valid      (ifu_valid),
        .idu_ready      (idu_ready),
        .fu_to_du_bus   (fu_to_du_bus),
        .exu_dnpc_valid (exu_dnpc_valid),
        .exu_dnpc       (exu_dnpc)
    );

    // Clock / cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h8000_0000, 32'h8000_0004: return 32'h0000_0013;
            32'h8000_0008: return 32'h0010_0093;
            32'h8000_000c: return 32'hfff0_0113;
            32'h8000_0100: return 32'h0020_0113;
            32'h8000_0104: return 32'h0050_0293;
            32'h8000_0200: return 32'h0030_0193;
            32'h8000_0204: return 32'h0060_0313;
            32'h8000_0300: return 32'h0040_0213;
            default:       return 32'h0000_0073;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit cond(input int what);
        case (what)
            0:       return ifu_valid;
            1:       return ifu_req_valid;
            default: return ifu_req_valid && ifu_req_ready;
        endcase
    endfunction

    // Bounded wait (at negedges) for a DUT condition; expiry counts as a failure.
    task automatic wait_for(input int what, input string name);
        int n;
        n = 0;
        while (!cond(what) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks = checks + 1;
        if (!cond(what)) begin
            errors = errors + 1;
            $display("FAIL %s: got timeout expected event", name);
        end
    endtask

    task automatic consume();
        wait_for(0, "wait_ifu_valid");
        idu_ready = 1'b1;
        @(negedge clk);
        idu_ready = 1'b0;
    endtask

    // Memory model: sampled just after negedge, so inputs set at the negedge are settled
    initial begin
        bit          busy;
        int          dly;
        logic [31:0] addr;
        busy = 1'b0;
        dly = 0;
        addr = '0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_data = '0;
        forever begin
            @(negedge clk);
            #1;
            ifu_rsp_valid = 1'b0;
            if (!rst) begin
                busy = 1'b0;
            end else begin
                if (busy) begin
                    if (dly == 0) begin
                        ifu_rsp_valid = 1'b1;
                        ifu_rsp_data = mem_word(addr);
                        busy = 1'b0;
                    end else begin
                        dly--;
                    end
                end
                if (ifu_req_valid && ifu_req_ready) begin
                    busy = 1'b1;
                    dly = mem_lat - 1;
                    addr = ifu_req_addr;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted request and every new instruction
    initial begin
        logic vld_prev;
        vld_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (ifu_req_valid && ifu_req_ready) begin
                acc_cyc.push_back(cyc);
                if (exp_req_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL req_addr: got unexpected request %h expected none", ifu_req_addr);
                end else begin
                    check("req_addr", {32'h0, ifu_req_addr}, {32'h0, exp_req_q.pop_front()});
                end
            end
            if (ifu_valid && !vld_prev) begin
                if (exp_bus_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL fu_to_du_bus: got unexpected instruction %h expected none", fu_to_du_bus);
                end else begin
                    check("fu_to_du_bus", fu_to_du_bus, exp_bus_q.pop_front());
                end
            end
            vld_prev = ifu_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errors = errors + 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Directed stimulus
    initial begin
        rst = 1'b0;
        ifu_req_ready = 1'b0;
        idu_ready = 1'b0;
        exu_dnpc_valid = 1'b0;
        exu_dnpc = '0;
        repeat (2) @(negedge clk);
        check("rst_req_valid", {63'h0, ifu_req_valid}, 64'h0);
        check("rst_req_addr", {32'h0, ifu_req_addr}, 64'h8000_0000);
        check("rst_ifu_valid", {63'h0, ifu_valid}, 64'h0);
        check("rst_bus", fu_to_du_bus, 64'h0);

        // Zero-wait fetches from reset
        exp_req_q.push_back(32'h8000_0000);
        exp_req_q.push_back(32'h8000_0004);
        exp_bus_q.push_back({32'h8000_0000, 32'h0000_0013});
        exp_bus_q.push_back({32'h8000_0004, 32'h0000_0013});
        ifu_req_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("req_valid_after_reset", {63'h0, ifu_req_valid}, 64'h1);
        consume();
        consume();
        check("accepts_seen", 64'(acc_cyc.size()), 64'd2);
        if (acc_cyc.size() >= 2)
            check("fetch_period", 64'(acc_cyc[1] - acc_cyc[0]), 64'd4);

        // Backpressure while holding an instruction
        exp_req_q.push_back(32'h8000_0008);
        exp_bus_q.push_back({32'h8000_0008, 32'h0010_0093});
        wait_for(0, "wait_hold");
        for (int i = 0; i < 5; i++) begin
            check("bp_ifu_valid", {63'h0, ifu_valid}, 64'h1);
            check("bp_bus", fu_to_du_bus, {32'h8000_0008, 32'h0010_0093});
            check("bp_no_req", {63'h0, ifu_req_valid}, 64'h0);
            @(negedge clk);
        end
        mem_lat = 3;
        consume();

        // Redirect in WAIT; stale response arrives two cycles later and is dropped
        exp_req_q.push_back(32'h8000_000c);
        wait_for(2, "wait_accept_000c");
        @(negedge clk);
        exu_dnpc_valid = 1'b1;
        exu_dnpc = 32'h8000_0100;
        @(negedge clk);
        exu_dnpc_valid = 1'b0;
        mem_lat = 1;
        exp_req_q.push_back(32'h8000_0100);
        exp_bus_q.push_back({32'h8000_0100, 32'h0020_0113});
        consume();

        // Redirect in HOLD together with idu_ready; misaligned target
        exp_req_q.push_back(32'h8000_0104);
        exp_bus_q.push_back({32'h8000_0104, 32'h0050_0293});
        wait_for(0, "wait_hold_0104");
        idu_ready = 1'b1;
        exu_dnpc_valid = 1'b1;
        exu_dnpc = 32'h8000_0202;
        @(negedge clk);
        idu_ready = 1'b0;
        exu_dnpc_valid = 1'b0;
        exp_req_q.push_back(32'h8000_0200);
        exp_bus_q.push_back({32'h8000_0200, 32'h0030_0193});

        // Redirect in REQ while memory stalls for 3 cycles
        wait_for(0, "wait_hold_0200");
        idu_ready = 1'b1;
        @(negedge clk);
        idu_ready = 1'b0;
        ifu_req_ready = 1'b0;
        wait_for(1, "wait_req_0204");
        exu_dnpc_valid = 1'b1;
        exu_dnpc = 32'h8000_0300;
        check("stall_addr0", {32'h0, ifu_req_addr}, 64'h8000_0204);
        @(negedge clk);
        exu_dnpc_valid = 1'b0;
        check("stall_addr1", {32'h0, ifu_req_addr}, 64'h8000_0204);
        @(negedge clk);
        check("stall_addr2", {32'h0, ifu_req_addr}, 64'h8000_0204);
        check("stall_req_valid", {63'h0, ifu_req_valid}, 64'h1);
        exp_req_q.push_back(32'h8000_0204);
        exp_req_q.push_back(32'h8000_0300);
        exp_bus_q.push_back({32'h8000_0300, 32'h0040_0213});
        @(negedge clk);
        ifu_req_ready = 1'b1;

        // Asynchronous reset while WAITing on a slow response
        wait_for(0, "wait_hold_0300");
        idu_ready = 1'b1;
        mem_lat = 4;
        exp_req_q.push_back(32'h8000_0304);
        @(negedge clk);
        idu_ready = 1'b0;
        wait_for(2, "wait_accept_0304");
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_req_valid", {63'h0, ifu_req_valid}, 64'h0);
        check("arst_req_addr", {32'h0, ifu_req_addr}, 64'h8000_0000);
        check("arst_ifu_valid", {63'h0, ifu_valid}, 64'h0);
        check("arst_bus", fu_to_du_bus, 64'h0);
        @(negedge clk);
        @(negedge clk);
        mem_lat = 1;
        exp_req_q.push_back(32'h8000_0000);
        exp_bus_q.push_back({32'h8000_0000, 32'h0000_0013});
        rst = 1'b1;
        @(negedge clk);
        check("req_valid_after_arst", {63'h0, ifu_req_valid}, 64'h1);
        wait_for(0, "wait_hold_restart");
        idu_ready = 1'b1;
        ifu_req_ready = 1'b0;
        @(negedge clk);
        idu_ready = 1'b0;
        repeat (5) @(negedge clk);

        check("exp_req_empty", 64'(exp_req_q.size()), 64'd0);
        check("exp_bus_empty", 64'(exp_bus_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25020037_ifu.md
# ysyx_25020037_ifu

Instruction fetch unit of the multi-cycle NPC core: it owns the PC, fetches one 32-bit instruction at a time from instruction memory over a valid/ready request/response bus, and delivers `{pc, inst}` to the decode stage under an `ifu_valid`/`idu_ready` handshake. It is the producer end of the fetch-to-decode interface. It also takes PC redirects from the execute stage, covering jumps, taken branches, `ecall` and `mret`.

## Interface
- `RESET_PC`, default 32'h8000_0000: first fetch address after reset.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `ifu_req_valid`  out  1  fetch request valid.
- `ifu_req_ready`  in  1  memory accepts the request.
- `ifu_req_addr`  out  32  word-aligned fetch address.
- `ifu_rsp_valid`  in  1  read data valid, exactly one per accepted request.
- `ifu_rsp_data`  in  32  instruction word.
- `ifu_valid`  out  1  `fu_to_du_bus` holds a valid instruction.
- `idu_ready`  in  1  decode stage consumes the instruction this cycle.
- `fu_to_du_bus`  out  `FU_TO_DU_BUS_WD` (64)  `{pc[31:0], inst[31:0]}`, pc in the MSBs.
- `exu_dnpc_valid`  in  1  redirect strobe, one cycle wide.
- `exu_dnpc`  in  32  redirect target.

## Operation
- Maintains one outstanding request at most. There is no prefetch and no buffering beyond one instruction.
- FSM states: REQ, WAIT, HOLD. Reset enters REQ with `pc = RESET_PC`.
- **REQ**
  - `ifu_req_valid = 1`, `ifu_req_addr = pc`.
  - Address is stable until `ifu_req_valid & ifu_req_ready`. On that handshake, go to WAIT.
- **WAIT**
  - On `ifu_rsp_valid`, register `{pc, ifu_rsp_data}` into `fu_to_du_bus` and go to HOLD.
  - If the discard flag is set, drop the response instead, clear the flag, and go to REQ.
- **HOLD**
  - `ifu_valid = 1`. Bus contents are frozen.
  - On `ifu_valid & idu_ready`: set `pc <= pc + 4` (32-bit wrap, no overflow detection), `ifu_valid <= 0`, and go to REQ.
- **Redirect** (`exu_dnpc_valid`) has priority over every other same-cycle event.
  - In REQ without acceptance: `pc <= exu_dnpc`. The target is latched in a pending register and the current request stays unchanged, so the address-stability rule is honoured. On acceptance, go to WAIT with the discard flag set. When the discard completes, fetch resumes at the pending target.
  - In REQ with acceptance the same cycle: same as the previous case. The accepted old-address request is discarded.
  - In WAIT: set the discard flag and load `pc <= exu_dnpc`. If `ifu_rsp_valid` arrives the same cycle, that response is discarded immediately and the next state is REQ.
  - In HOLD: `ifu_valid <= 0`, `pc <= exu_dnpc`, go to REQ. This applies even if `idu_ready` is asserted the same cycle, in which case no `pc + 4` is applied.
- Misaligned `exu_dnpc` (bits [1:0] ≠ 0) is forced aligned by zeroing bits [1:0]. No exception is raised.
- `rst` low in any state: immediately return to reset values. Any in-flight response after reset release is not expected; memory must be reset in the same domain.

## Timing
- Reset values:
  - `ifu_req_valid = 0`, `ifu_req_addr = RESET_PC`.
  - `ifu_valid = 0`, `fu_to_du_bus = 0`.
  - pc = `RESET_PC`, discard flag = 0, pending register empty.
- `ifu_req_valid` rises in the first cycle after `rst` deasserts.
- All outputs are registered.
  - `ifu_valid` rises one cycle after `ifu_rsp_valid`.
  - `ifu_req_valid` rises one cycle after the consuming handshake.
- Minimum fetch-to-fetch period with a zero-wait memory (ready held high, response one cycle after acceptance): 4 cycles.
- `ifu_valid` remains asserted until consumed or redirected. It never drops while waiting for `idu_ready`.

## Structure
- Shared config header/package holds:
  - `FU_TO_DU_BUS_WD` = 64.
  - Default `RESET_PC`.
  - The FSM state encoding (2 bits: REQ = 0, WAIT = 1, HOLD = 2).
- No sub-module. The FSM, pc register, pending-redirect register and discard flag are all inline.

## Test plan
- Reset release with a zero-wait memory returning 32'h0000_0013:
  - Requests at 8000_0000 and 8000_0004 in turn.
  - `fu_to_du_bus` = {8000_0000, 0000_0013}, then {8000_0004, 0000_0013}.
  - Requests are 4 cycles apart.
- Backpressure: hold `idu_ready = 0` for 5 cycles.
  - `ifu_valid` and the bus stay constant.
  - No new request is issued.
- Redirect in WAIT to 8000_0100, with the response arriving 2 cycles later:
  - That response is dropped and `ifu_valid` never asserts for it.
  - The next request address is 8000_0100.
- Redirect in HOLD, same cycle as `idu_ready = 1`:
  - Next request address = `exu_dnpc`, not pc + 4.
- Redirect in REQ with `ifu_req_ready = 0` for 3 cycles:
  - Address stays at the old pc until accepted.
  - That fetch is discarded, then the target is fetched.
- Assert `rst` (low) while in WAIT:
  - All outputs return to reset values asynchronously.
  - Fetch restarts at `RESET_PC`.
